// File: rtl/hid_evq.sv
// hid_evq: HID command decoder with a paced keyboard/mouse event FIFO.
//   clk, reset_n            clock, async active-low reset
//   data_in_strobe/start    MCU byte valid / byte is a command
//   data_in, data_out       MCU byte in, reply byte out
//   db9_port, irq, iack     local DB9 lines, change interrupt, acknowledge
//   mouse_buttons           current mouse buttons
//   evt_level/type/data     toggle-per-event stream to the core
//   joystick                JOY_CH bytes, channel n at [8n+7:8n]
//   overflow                sticky event-drop flag
module hid_evq #(
    parameter int JOY_CH     = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int EVT_GAP    = 16,
    parameter int DB9_W      = 6
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                data_in_strobe,
    input  logic                data_in_start,
    input  logic [7:0]          data_in,
    output logic [7:0]          data_out,
    input  logic [DB9_W-1:0]    db9_port,
    output logic                irq,
    input  logic                iack,
    output logic [2:0]          mouse_buttons,
    output logic                evt_level,
    output logic [1:0]          evt_type,
    output logic [7:0]          evt_data,
    output logic [8*JOY_CH-1:0] joystick,
    output logic                overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int GW = (EVT_GAP > 1) ? $clog2(EVT_GAP) : 1;
    localparam logic [AW:0]   FULL       = (AW+1)'(FIFO_DEPTH);
    localparam logic [GW-1:0] GAP_RELOAD = GW'(EVT_GAP - 1);

    logic [3:0]          state_q, state_d;
    logic [7:0]          cmd_q, cmd_d, dev_q, dev_d, data_out_q, data_out_d, evt_data_q, evt_data_d;
    logic [2:0]          mouse_q, mouse_d;
    logic [1:0]          evt_type_q, evt_type_d;
    logic                evt_level_q, evt_level_d, irq_q, irq_d, irq_en_q, irq_en_d, overflow_q, overflow_d;
    logic [8*JOY_CH-1:0] joy_q, joy_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]         count_q, count_d;
    logic [GW-1:0]       gap_q, gap_d;
    logic [DB9_W-1:0]    db9_s1_q, db9_s2_q;
    logic [9:0]          fifo_mem [FIFO_DEPTH];
    logic                push, push_ok, pop;
    logic [1:0]          push_type;
    logic [7:0]          push_data;

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        dev_d       = dev_q;
        data_out_d  = data_out_q;
        mouse_d     = mouse_q;
        joy_d       = joy_q;
        irq_d       = irq_q;
        irq_en_d    = irq_en_q;
        overflow_d  = overflow_q;
        evt_level_d = evt_level_q;
        evt_type_d  = evt_type_q;
        evt_data_d  = evt_data_q;
        push        = 1'b0;
        push_type   = 2'd0;
        push_data   = 8'd0;
        // One interrupt per arming; iack wins over a simultaneous set.
        if (irq_en_q && db9_s1_q != db9_s2_q) begin
            irq_d    = 1'b1;
            irq_en_d = 1'b0;
        end
        if (iack)
            irq_d = 1'b0;
        if (data_in_strobe) begin
            if (data_in_start) begin
                state_d = 4'd1;
                cmd_d   = data_in;
            end else if (state_q != 4'd0) begin
                state_d = (state_q == 4'd15) ? state_q : state_q + 4'd1;
                case (cmd_q)
                    8'd0: begin
                        if (state_q == 4'd1) data_out_d = 8'h5c;
                        if (state_q == 4'd2) data_out_d = 8'h43;
                        if (state_q == 4'd3) begin
                            data_out_d = 8'(count_q);
                            overflow_d = 1'b0;
                        end
                    end
                    8'd1: begin
                        push      = 1'b1;
                        push_type = 2'd2;
                        push_data = data_in;
                    end
                    8'd2: begin
                        if (state_q == 4'd1) mouse_d = data_in[2:0];
                        push      = (state_q == 4'd2 || state_q == 4'd3) && data_in != 8'd0;
                        push_type = (state_q == 4'd3) ? 2'd1 : 2'd0;
                        push_data = data_in;
                    end
                    8'd3: begin
                        if (state_q == 4'd1) dev_d = data_in;
                        if (state_q == 4'd2)
                            for (int i = 0; i < JOY_CH; i++)
                                if (dev_q == 8'(i)) joy_d[8*i +: 8] = data_in;
                    end
                    8'd4: begin
                        if (state_q == 4'd1) irq_en_d = 1'b1;
                        data_out_d = 8'(db9_s2_q);
                    end
                    default: ;
                endcase
            end
        end
        pop = (gap_q == '0) && (count_q != '0);
        // A full queue still accepts when its head leaves in the same cycle.
        push_ok = push && (count_q < FULL || pop);
        if (push && !push_ok)
            overflow_d = 1'b1;
        if (pop) begin
            evt_type_d  = fifo_mem[rd_ptr_q][9:8];
            evt_data_d  = fifo_mem[rd_ptr_q][7:0];
            evt_level_d = ~evt_level_q;
        end
        gap_d    = pop ? GAP_RELOAD : (gap_q != '0) ? gap_q - 1'b1 : gap_q;
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= '0;
            cmd_q       <= '0;
            dev_q       <= '0;
            data_out_q  <= '0;
            mouse_q     <= '0;
            joy_q       <= '0;
            irq_q       <= 1'b0;
            irq_en_q    <= 1'b0;
            overflow_q  <= 1'b0;
            evt_level_q <= 1'b0;
            evt_type_q  <= '0;
            evt_data_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            gap_q       <= '0;
            db9_s1_q    <= '0;
            db9_s2_q    <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            dev_q       <= dev_d;
            data_out_q  <= data_out_d;
            mouse_q     <= mouse_d;
            joy_q       <= joy_d;
            irq_q       <= irq_d;
            irq_en_q    <= irq_en_d;
            overflow_q  <= overflow_d;
            evt_level_q <= evt_level_d;
            evt_type_q  <= evt_type_d;
            evt_data_q  <= evt_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            gap_q       <= gap_d;
            db9_s1_q    <= db9_port;
            db9_s2_q    <= db9_s1_q;
        end
    end

    // Queue storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk)
        if (push_ok)
            fifo_mem[wr_ptr_q] <= {push_type, push_data};

    assign data_out      = data_out_q;
    assign irq           = irq_q;
    assign mouse_buttons = mouse_q;
    assign evt_level     = evt_level_q;
    assign evt_type      = evt_type_q;
    assign evt_data      = evt_data_q;
    assign joystick      = joy_q;
    assign overflow      = overflow_q;
endmodule
